mem_bus_master: RTL and testbench
=================================

Name: mem_bus_master

Overview:
CPU-side initiator for the byte-wide memory bus served by the testbench memory model. It accepts one byte, halfword or word load/store request at a time from the core. It serialises each request into little-endian byte transfers on the memory bus and returns a single response pulse. All bus protocol timing, the memory model's address-change rule, and timeout detection live here.

Parameters:
TIMEOUT, 16, cycles to wait for mem_ready on one read byte before aborting with an error (minimum 2).

Ports:
clk  in  1  clock; all logic on posedge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  core request strobe
req_ready  out  1  high only in IDLE; request accepted on req_valid && req_ready
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
req_addr  in  32  byte address; any alignment allowed
req_wdata  in  32  store data; byte i = bits [8i+7:8i]
resp_valid  out  1  one-cycle completion pulse; no backpressure
resp_rdata  out  32  load data, zero-extended; 0 for stores and errors
resp_err  out  1  valid with resp_valid; timeout or illegal size
mem_addr  out  32  bus address
mem_data_out  out  8  write byte (drives the memory's data_in)
mem_data_in  in  8  read byte (driven by the memory's data_out)
mem_read_en  out  1  read strobe
mem_write_en  out  1  write strobe
mem_ready  in  1  one-cycle read-data-valid pulse from memory

Behaviour:
- Reset (rst_n low at a posedge):
  - State goes to IDLE.
  - All outputs are 0, including req_ready, resp_* and mem_*.
  - Reset mid-transaction aborts it: strobes drop at that edge, no resp_valid is issued, the partial store is not undone.
- Request capture:
  - req_ready = (state==IDLE) && rst_n.
  - On accept, latch we, size, addr and wdata.
  - N = 1/2/4 bytes for size 00/01/10.
  - Byte i address = addr + i, mod 2^32; wraps 0xFFFFFFFF -> 0x00000000.
- States: IDLE, RD, WR, RESP.
- IDLE:
  - Bus outputs are all 0.
  - On accept: size 11 -> RESP with err=1 and no bus activity; we=1 -> WR; else -> RD.
  - Byte index i = 0, timeout counter = 0.
- WR:
  - Each cycle drive mem_addr=addr+i, mem_data_out=wdata byte i, mem_write_en=1, mem_read_en=0.
  - Advance i every cycle.
  - After byte N-1, go to RESP.
  - A store occupies N bus cycles.
- RD:
  - Drive mem_addr=addr+i, mem_read_en=1, mem_write_en=0.
  - On the posedge where mem_ready=1: capture mem_data_in into rdata byte i, clear the timeout counter, advance i, and present the new address from that edge.
  - mem_read_en stays high between bytes.
  - After byte N-1 is captured, go to RESP.
  - The memory responds only when the address differs from its last read address. Nominal cost is therefore 2 cycles per byte, with byte i captured at the edge 2i+2 after accept.
  - The timeout counter increments on each RD cycle without mem_ready. When it reaches TIMEOUT: abort, rdata=0, err=1, go to RESP.
  - mem_ready outside RD is ignored.
- RESP:
  - resp_valid=1 for exactly one cycle with resp_rdata and resp_err; bus outputs are 0.
  - Next state is IDLE.
- Latency from the accept edge to the resp_valid cycle:
  - Load: 2N+1 cycles.
  - Store: N+1 cycles.
  - Illegal size: 1 cycle.
  - Timeout: up to TIMEOUT cycles on the failing byte plus 1.
- Known limitation: an immediate re-read of the same last byte address gets no mem_ready and ends in a timeout error. Any intervening store clears this condition in the memory.

Test Plan:
1. Store word 0xDEADBEEF @0x20 -> cycles 1-4: write_en=1, addr 0x20..0x23, data EF,BE,AD,DE; resp_valid in cycle 5, err=0, rdata=0.
2. After test 1, load word @0x20 -> read_en high cycles 1-8, addr 0x20..0x23; resp_valid in cycle 9, rdata=0xDEADBEEF, err=0.
3. Load halfword @0xFFFFFFFF with mem[0xFF]=0x12, mem[0x00]=0x34 -> addresses 0xFFFFFFFF then 0x00000000; rdata=0x00003412.
4. Load byte @0x40 twice back to back, no store between -> first returns mem[0x40]; second has no mem_ready, resp_err=1 and rdata=0 after TIMEOUT=16 cycles; req_ready returns the following cycle.
5. req_size=11, req_we=1 -> no strobes; resp_valid with err=1 in cycle 1.
6. Load word, pull rst_n low after byte 1 is captured -> strobes 0 after that edge, no resp_valid; rst_n high -> req_ready=1, and a new load completes normally.

Source files
------------

// File: rtl/mem_bus_master.sv
// Core-side initiator that splits byte/half/word loads and stores
// into little-endian byte transfers on the byte-wide memory bus.
module mem_bus_master #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_data_out,
  input  logic [7:0]  mem_data_in,
  output logic        mem_read_en,
  output logic        mem_write_en,
  input  logic        mem_ready
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    RESP
  } state_t;

  state_t        state;
  logic [1:0]    size_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic [1:0]    idx;
  logic [TW-1:0] tcnt;

  logic [1:0]    last_idx;
  logic [1:0]    nidx;
  logic [7:0]    wbyte_n;
  logic [31:0]   rdata_m;
  logic [31:0]   addr_n;

  assign req_ready = (state == IDLE) && rst_n;

  always_comb begin
    last_idx = 2'd0;
    if (size_q == 2'b01) last_idx = 2'd1;
    if (size_q == 2'b10) last_idx = 2'd3;
  end

  assign nidx    = idx + 2'd1;
  assign addr_n  = addr_q + 32'(nidx);
  assign wbyte_n = wdata_q[{nidx, 3'b000} +: 8];

  // read data with the byte arriving this cycle merged in
  always_comb begin
    rdata_m = rdata_q;
    rdata_m[{idx, 3'b000} +: 8] = mem_data_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      size_q       <= 2'b00;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      idx          <= '0;
      tcnt         <= '0;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      mem_addr     <= '0;
      mem_data_out <= '0;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rdata_q <= '0;
            idx     <= '0;
            tcnt    <= '0;
            if (req_size == 2'b11) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (req_we) begin
              state        <= WR;
              mem_addr     <= req_addr;
              mem_data_out <= req_wdata[7:0];
              mem_write_en <= 1'b1;
            end else begin
              state       <= RD;
              mem_addr    <= req_addr;
              mem_read_en <= 1'b1;
            end
          end
        end
        WR: begin
          if (idx == last_idx) begin
            state        <= RESP;
            mem_addr     <= '0;
            mem_data_out <= '0;
            mem_write_en <= 1'b0;
            resp_valid   <= 1'b1;
            resp_err     <= 1'b0;
            resp_rdata   <= '0;
          end else begin
            idx          <= nidx;
            mem_addr     <= addr_n;
            mem_data_out <= wbyte_n;
          end
        end
        RD: begin
          if (mem_ready) begin
            tcnt    <= '0;
            rdata_q <= rdata_m;
            if (idx == last_idx) begin
              state       <= RESP;
              mem_addr    <= '0;
              mem_read_en <= 1'b0;
              resp_valid  <= 1'b1;
              resp_err    <= 1'b0;
              resp_rdata  <= rdata_m;
            end else begin
              idx      <= nidx;
              mem_addr <= addr_n;
            end
          end else if (tcnt == TLAST) begin
            state       <= RESP;
            mem_addr    <= '0;
            mem_read_en <= 1'b0;
            rdata_q     <= '0;
            resp_valid  <= 1'b1;
            resp_err    <= 1'b1;
            resp_rdata  <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master with a byte-wide memory model
// that only answers a read when the address moved.
module tb_mem_bus_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [7:0]  mem_data_out;
  logic [7:0]  mem_data_in;
  logic        mem_read_en;
  logic        mem_write_en;
  logic        mem_ready;

  always #5 clk = ~clk;

  mem_bus_master #(.TIMEOUT(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_addr     (mem_addr),
    .mem_data_out (mem_data_out),
    .mem_data_in  (mem_data_in),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .mem_ready    (mem_ready)
  );

  // memory model
  logic [7:0]  mem [256];
  logic [31:0] last_addr;
  logic        last_vld;

  always @(posedge clk) begin
    if (!rst_n) begin
      mem_ready   <= 1'b0;
      mem_data_in <= 8'h00;
      last_vld    <= 1'b0;
      last_addr   <= '0;
    end else begin
      mem_ready <= 1'b0;
      if (mem_write_en) begin
        mem[mem_addr[7:0]] <= mem_data_out;
        last_vld <= 1'b0;
      end else if (mem_read_en && !(last_vld && mem_addr == last_addr)) begin
        mem_ready   <= 1'b1;
        mem_data_in <= mem[mem_addr[7:0]];
        last_addr   <= mem_addr;
        last_vld    <= 1'b1;
      end
    end
  end

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  logic [31:0] bus_addr [8];
  logic [7:0]  bus_data [8];
  logic        rdy_seen;

  task automatic run_req(input logic we, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd,
                         output logic er, output int nwr,
                         output int nrd, output int nb);
    bit done;
    @(negedge clk);
    rdy_seen  = req_ready;
    req_valid = 1'b1;
    req_we    = we;
    req_size  = sz;
    req_addr  = a;
    req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = -1; rd = 'x; er = 1'bx;
    nwr = 0; nrd = 0; nb = 0; done = 0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clk);
      if (mem_write_en && nb < 8) begin
        bus_addr[nb] = mem_addr;
        bus_data[nb] = mem_data_out;
        nb++;
      end
      if (mem_write_en) nwr++;
      if (mem_read_en) begin
        nrd++;
        if (nb < 8 && (nb == 0 || bus_addr[nb-1] != mem_addr)) begin
          bus_addr[nb] = mem_addr;
          bus_data[nb] = 8'h00;
          nb++;
        end
      end
      if (resp_valid) begin
        lat = c;
        rd = resp_rdata;
        er = resp_err;
        done = 1;
        chk("bus_idle_in_resp", {30'd0, mem_read_en, mem_write_en}, 32'd0);
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
    int          lat;
    logic [31:0] rd;
    logic        er;
    int          nwr;
    int          nrd;
    int          nb;
  } vec_t;

  vec_t v [13];

  initial begin
    int lat, nwr, nrd, nb;
    logic [31:0] rd;
    logic er;
    bit seen;

    v[0]  = '{1'b1, 2'b10, 32'h20,       32'hDEADBEEF, 5,  32'h0,        1'b0, 4, 0,  4};
    v[1]  = '{1'b0, 2'b10, 32'h20,       32'h0,        9,  32'hDEADBEEF, 1'b0, 0, 8,  4};
    v[2]  = '{1'b1, 2'b00, 32'hFF,       32'h12,       2,  32'h0,        1'b0, 1, 0,  1};
    v[3]  = '{1'b1, 2'b00, 32'h00,       32'h34,       2,  32'h0,        1'b0, 1, 0,  1};
    v[4]  = '{1'b0, 2'b01, 32'hFFFFFFFF, 32'h0,        5,  32'h3412,     1'b0, 0, 4,  2};
    v[5]  = '{1'b1, 2'b01, 32'h41,       32'h1234A55A, 3,  32'h0,        1'b0, 2, 0,  2};
    v[6]  = '{1'b1, 2'b00, 32'h40,       32'hFFFFFF77, 2,  32'h0,        1'b0, 1, 0,  1};
    v[7]  = '{1'b0, 2'b01, 32'h41,       32'h0,        5,  32'hA55A,     1'b0, 0, 4,  2};
    v[8]  = '{1'b0, 2'b00, 32'h40,       32'h0,        3,  32'h77,       1'b0, 0, 2,  1};
    v[9]  = '{1'b0, 2'b00, 32'h40,       32'h0,        17, 32'h0,        1'b1, 0, 16, 1};
    v[10] = '{1'b1, 2'b11, 32'h40,       32'hCAFEF00D, 1,  32'h0,        1'b1, 0, 0,  0};
    v[11] = '{1'b0, 2'b11, 32'h10,       32'h0,        1,  32'h0,        1'b1, 0, 0,  0};
    v[12] = '{1'b0, 2'b10, 32'h20,       32'h0,        9,  32'hDEADBEEF, 1'b0, 0, 8,  4};

    rst_n = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_size = 2'b00;
    req_addr = '0;
    req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp", {30'd0, resp_valid, resp_err}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_strobes", {30'd0, mem_read_en, mem_write_en}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_data", {24'd0, mem_data_out}, 32'd0);
    rst_n = 1'b1;
    #1 chk("idle_req_ready", {31'd0, req_ready}, 32'd1);

    for (int k = 0; k < 13; k++) begin
      run_req(v[k].we, v[k].sz, v[k].a, v[k].wd, lat, rd, er, nwr, nrd, nb);
      chk($sformatf("v%0d_ready", k), {31'd0, rdy_seen}, 32'd1);
      chk($sformatf("v%0d_latency", k), lat, v[k].lat);
      chk($sformatf("v%0d_rdata", k), rd, v[k].rd);
      chk($sformatf("v%0d_err", k), {31'd0, er}, {31'd0, v[k].er});
      chk($sformatf("v%0d_wr_cycles", k), nwr, v[k].nwr);
      chk($sformatf("v%0d_rd_cycles", k), nrd, v[k].nrd);
      chk($sformatf("v%0d_bus_bytes", k), nb, v[k].nb);
      for (int i = 0; i < v[k].nb && i < nb; i++) begin
        chk($sformatf("v%0d_addr%0d", k, i), bus_addr[i], v[k].a + 32'(i));
        if (v[k].we)
          chk($sformatf("v%0d_data%0d", k, i), {24'd0, bus_data[i]},
              {24'd0, 8'(v[k].wd >> (8 * i))});
      end
    end

    // reset in the middle of a word load
    run_req(1'b1, 2'b10, 32'h80, 32'h11223344, lat, rd, er, nwr, nrd, nb);
    chk("pre_store_lat", lat, 5);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = 2'b10;
    req_addr  = 32'h80;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("mid_read_en", {31'd0, mem_read_en}, 32'd1);
    chk("mid_addr", mem_addr, 32'h82);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_strobes", {30'd0, mem_read_en, mem_write_en}, 32'd0);
    chk("abort_addr", mem_addr, 32'd0);
    chk("abort_resp", {31'd0, resp_valid}, 32'd0);
    chk("abort_ready_low", {31'd0, req_ready}, 32'd0);
    rst_n = 1'b1;
    #1 chk("abort_ready_high", {31'd0, req_ready}, 32'd1);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (resp_valid) seen = 1;
    end
    chk("abort_no_resp", {31'd0, seen}, 32'd0);
    run_req(1'b0, 2'b10, 32'h80, 32'h0, lat, rd, er, nwr, nrd, nb);
    chk("post_rst_lat", lat, 9);
    chk("post_rst_rdata", rd, 32'h11223344);
    chk("post_rst_err", {31'd0, er}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
